// File: rtl/mysystem_start_pkg.sv
// Shared types and PIO register map for the start sequencer.
package mysystem_start_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    CLR   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // PIO s1 register offsets: data, bit-set, bit-clear.
  localparam logic [2:0] PIO_ADDR_DATA = 3'd0;
  localparam logic [2:0] PIO_ADDR_SET  = 3'd4;
  localparam logic [2:0] PIO_ADDR_CLR  = 3'd5;

endpackage

// File: rtl/mysystem_start_sequencer_if.sv
// Requester handshake plus Avalon-MM PIO master bus of the start sequencer.
// master = sequencer side, slave = requesters / accelerator / PIO side.
interface mysystem_start_sequencer_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done_pulse;
  logic               busy;
  logic               accel_done;
  logic               err_clr;
  logic               timeout_err;
  logic [2:0]         m_address;
  logic               m_chipselect;
  logic               m_write_n;
  logic [31:0]        m_writedata;

  modport master (
    input  req, accel_done, err_clr,
    output grant, done_pulse, busy, timeout_err,
    output m_address, m_chipselect, m_write_n, m_writedata
  );

  modport slave (
    output req, accel_done, err_clr,
    input  grant, done_pulse, busy, timeout_err,
    input  m_address, m_chipselect, m_write_n, m_writedata
  );
endinterface

// File: rtl/mysystem_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer.
module mysystem_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PW-1:0]      o_idx,
  output logic               o_valid
);

  // Scan NUM_REQ positions starting at the pointer, wrapping; first hit wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_valid && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_valid = 1'b1;
        o_idx   = PW'((int'(i_ptr) + k) % NUM_REQ);
        o_gnt[(int'(i_ptr) + k) % NUM_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mysystem_start_sequencer.sv
// Shares one start PIO / accelerator among NUM_REQ requesters:
// arbitrate, write bit-set, wait for accel done (or timeout), write bit-clear.
module mysystem_start_sequencer
  import mysystem_start_pkg::*;
#(
  parameter int          NUM_REQ        = 4,
  parameter logic [31:0] START_MASK     = 32'h1,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  reset,
  mysystem_start_sequencer_if.master bus
);

  localparam int PW = $clog2(NUM_REQ);
  // Timer must hold TIMEOUT_CYCLES; keep at least one bit when timeout is disabled.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t             r_state;
  logic [PW-1:0]      r_ptr;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_done;
  logic               r_busy;
  logic               r_terr;
  logic               r_cs;
  logic               r_wn;
  logic [2:0]         r_addr;
  logic [31:0]        r_wd;
  logic [TW-1:0]      r_timer;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [PW-1:0]      w_arb_idx;
  logic               w_arb_vld;
  logic [PW-1:0]      w_ptr_nxt;
  logic               w_tmo_fire;

  mysystem_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_vld)
  );

  assign w_ptr_nxt  = (w_arb_idx == PW'(NUM_REQ - 1)) ? '0 : w_arb_idx + 1'b1;
  // Done takes priority over a coincident timeout.
  assign w_tmo_fire = (TIMEOUT_CYCLES != 0) && (r_state == RUN) &&
                      !bus.accel_done && (r_timer == TMO_LAST);

  // FSM, timer and registered Avalon write strobes; bus writes occur only in SET and CLR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_terr  <= 1'b0;
      r_cs    <= 1'b0;
      r_wn    <= 1'b1;
      r_addr  <= PIO_ADDR_DATA;
      r_wd    <= '0;
      r_timer <= '0;
    end else begin
      r_done <= '0;
      r_cs   <= 1'b0;
      r_wn   <= 1'b1;
      case (r_state)
        IDLE: if (w_arb_vld) begin
          r_grant <= w_arb_gnt;
          r_ptr   <= w_ptr_nxt;
          r_busy  <= 1'b1;
          r_cs    <= 1'b1;
          r_wn    <= 1'b0;
          r_addr  <= PIO_ADDR_SET;
          r_wd    <= START_MASK;
          r_state <= SET;
        end
        SET: begin
          r_timer <= '0;
          r_state <= RUN;
        end
        RUN: begin
          if (bus.accel_done || w_tmo_fire) begin
            r_done  <= bus.accel_done ? r_grant : '0;
            r_cs    <= 1'b1;
            r_wn    <= 1'b0;
            r_addr  <= PIO_ADDR_CLR;
            r_wd    <= START_MASK;
            r_state <= CLR;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        CLR: r_state <= DRAIN;
        DRAIN: if (!bus.accel_done) begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // Sticky error: a new timeout beats a simultaneous clear.
      if (w_tmo_fire)       r_terr <= 1'b1;
      else if (bus.err_clr) r_terr <= 1'b0;
    end
  end

  assign bus.grant        = r_grant;
  assign bus.done_pulse   = r_done;
  assign bus.busy         = r_busy;
  assign bus.timeout_err  = r_terr;
  assign bus.m_chipselect = r_cs;
  assign bus.m_write_n    = r_wn;
  assign bus.m_address    = r_addr;
  assign bus.m_writedata  = r_wd;

endmodule
